serial_addsub: RTL and testbench

- Multi-cycle, digit-serial add/subtract engine for the arithmetic datapath.
- Processes DIGIT bits per clock, LSB first, from latched operands.
- In subtract mode it returns magnitude |num1 - num2| plus a sign flag. In add mode it returns the sum plus carry.
- Uses a start/ready/done handshake so a controlling FSM can issue one operation at a time.

---
 rtl/serial_addsub.sv | 152 +++++++++++++++
 tb/tb_serial_addsub.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Digit-serial unsigned add / subtract engine. Operands are latched on an
// accepted start and processed DIGIT bits per clock, LSB first, over
// N = BITS/DIGIT CALC cycles. Subtraction is computed as A + ~B + 1; when the
// final carry is 0 (A < B) one extra FIX cycle negates the working sum so the
// result is always the magnitude |A - B|.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      operation request, accepted only while ready = 1
//   mode       0 = add, 1 = subtract (sampled with start)
//   num1       operand A (sampled with start)
//   num2       operand B (sampled with start)
//   ready      high only while idle
//   done       single-cycle pulse, result and flags valid
//   result     sum (add) or magnitude |A - B| (sub)
//   carry_out  add: carry out of MSB; sub: 1 when A >= B
//   negative   sub and A < B; always 0 for add
//
// DIGIT must divide BITS exactly.
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int BITS  = 8,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic [BITS-1:0] num1,
    input  logic [BITS-1:0] num2,
    output logic            ready,
    output logic            done,
    output logic [BITS-1:0] result,
    output logic            carry_out,
    output logic            negative
);

    localparam int N     = BITS / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [BITS-1:0]   a_reg, b_reg, sum_reg;
    logic              mode_reg, carry_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [DIGIT-1:0]  a_dig, b_dig;
    logic [DIGIT:0]    dig_sum;
    logic [BITS-1:0]   sum_upd;
    logic              last_dig;

    // Current digit slice; B is inverted in subtract mode, the +1 of the
    // two's complement comes from the working carry seeded with mode.
    always_comb begin
        a_dig    = a_reg[int'(cnt_reg) * DIGIT +: DIGIT];
        b_dig    = b_reg[int'(cnt_reg) * DIGIT +: DIGIT];
        if (mode_reg) begin
            b_dig = ~b_dig;
        end
        dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_reg};
        sum_upd  = sum_reg;
        sum_upd[int'(cnt_reg) * DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
        last_dig = (cnt_reg == CNT_W'(N - 1));
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = CALC;
            CALC: begin
                if (last_dig) begin
                    // A subtract that ends without a carry out borrowed,
                    // so the sum is negative and needs negating.
                    state_next = (mode_reg && !dig_sum[DIGIT]) ? FIX : DONE;
                end
            end
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers. Outputs only load on the edge that
    // enters DONE, so they hold the previous result while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            mode_reg  <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= num1;
                        b_reg     <= num2;
                        mode_reg  <= mode;
                        carry_reg <= mode;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                    end
                end
                CALC: begin
                    sum_reg   <= sum_upd;
                    carry_reg <= dig_sum[DIGIT];
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_dig && state_next == DONE) begin
                        result    <= sum_upd;
                        carry_out <= dig_sum[DIGIT];
                        negative  <= 1'b0;
                    end
                end
                FIX: begin
                    sum_reg   <= ~sum_reg + BITS'(1);
                    result    <= ~sum_reg + BITS'(1);
                    carry_out <= 1'b0;
                    negative  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (state_reg == IDLE);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Drives three serial_addsub instances (BITS=8 with DIGIT = 1, 4, 8, i.e.
// N = 8, 2, 1) from shared stimulus and compares each against a plain
// arithmetic reference: A+B or |A-B| with the expected latency.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] num1;
    logic [7:0] num2;

    logic [2:0] ready_w;
    logic [2:0] done_w;
    logic [2:0] carry_w;
    logic [2:0] neg_w;
    logic [7:0] res_w [3];

    int checks   = 0;
    int failures = 0;

    serial_addsub #(.BITS(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .num1(num1), .num2(num2), .ready(ready_w[0]), .done(done_w[0]),
        .result(res_w[0]), .carry_out(carry_w[0]), .negative(neg_w[0])
    );

    serial_addsub #(.BITS(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .num1(num1), .num2(num2), .ready(ready_w[1]), .done(done_w[1]),
        .result(res_w[1]), .carry_out(carry_w[1]), .negative(neg_w[1])
    );

    serial_addsub #(.BITS(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .num1(num1), .num2(num2), .ready(ready_w[2]), .done(done_w[2]),
        .result(res_w[2]), .carry_out(carry_w[2]), .negative(neg_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 2 : 1);
    endfunction

    function automatic int digit_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One operation on all instances; checks results, flags, latency and
    // that exactly one done pulse is produced.
    task automatic run_op(input logic m, input logic [7:0] a,
                          input logic [7:0] b, input bit inject);
        int      lat   [3];
        int      ndone [3];
        int      sum;
        logic [7:0] e_res;
        logic       e_carry;
        logic       e_neg;
        int         extra;
        string      t;

        if (m == 1'b0) begin
            sum     = int'(a) + int'(b);
            e_res   = sum[7:0];
            e_carry = sum[8];
            e_neg   = 1'b0;
            extra   = 0;
        end else if (a >= b) begin
            e_res   = a - b;
            e_carry = 1'b1;
            e_neg   = 1'b0;
            extra   = 0;
        end else begin
            e_res   = b - a;
            e_carry = 1'b0;
            e_neg   = 1'b1;
            extra   = 1;
        end

        @(negedge clk);
        check_eq("ready_before_start", 32'(ready_w), 32'h7);
        start = 1'b1; mode = m; num1 = a; num2 = b;
        @(posedge clk);
        #1;
        // Inputs changed after the accept edge must not matter.
        start = inject; mode = ~m; num1 = 8'($urandom); num2 = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0; ndone[i] = 0;
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    ndone[i]++;
                    if (lat[i] == 0) lat[i] = k;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            t = $sformatf("d%0d", digit_of(i));
            check_eq({t, "_latency"},  32'(lat[i]), 32'(n_of(i) + extra));
            check_eq({t, "_ndone"},    32'(ndone[i]), 32'd1);
            check_eq({t, "_result"},   32'(res_w[i]), 32'(e_res));
            check_eq({t, "_carry"},    32'(carry_w[i]), 32'(e_carry));
            check_eq({t, "_negative"}, 32'(neg_w[i]), 32'(e_neg));
        end
        $display("op mode=%0d a=%0d b=%0d inject=%0d exp_res=%0d exp_c=%0d exp_n=%0d",
                 m, a, b, inject, e_res, e_carry, e_neg);
    endtask

    function automatic logic [7:0] pick_operand();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 8'd0;
        if (r == 1) return 8'd255;
        return 8'($urandom);
    endfunction

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       m;

        rst_n = 1'b1; start = 1'b0; mode = 1'b0; num1 = '0; num2 = '0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("d%0d_reset_result", digit_of(i)), 32'(res_w[i]), 32'd0);
            check_eq($sformatf("d%0d_reset_flags", digit_of(i)),
                     32'({carry_w[i], neg_w[i], done_w[i]}), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_reset", 32'(ready_w), 32'h7);

        // Directed cases
        run_op(1'b0, 8'd200, 8'd100, 1'b0);
        run_op(1'b1, 8'd100, 8'd30,  1'b0);
        run_op(1'b1, 8'd55,  8'd55,  1'b0);
        run_op(1'b1, 8'd30,  8'd100, 1'b0);
        run_op(1'b1, 8'd0,   8'd255, 1'b0);
        run_op(1'b0, 8'd255, 8'd255, 1'b0);
        run_op(1'b0, 8'd0,   8'd0,   1'b0);
        // start pulsed while busy with other operands: ignored
        run_op(1'b0, 8'd200, 8'd100, 1'b1);

        // start held high: issue every N+2 edges, single-cycle done,
        // outputs stable between pulses.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; num1 = 8'd200; num2 = 8'd100;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("d%0d_held_done_c%0d", digit_of(i), c),
                         32'(done_w[i]),
                         32'((c >= n_of(i)) && ((c - n_of(i)) % (n_of(i) + 2) == 0)));
                if (c >= n_of(i)) begin
                    check_eq($sformatf("d%0d_held_stable_c%0d", digit_of(i), c),
                             32'({res_w[i], carry_w[i], neg_w[i]}),
                             32'({8'd44, 1'b1, 1'b0}));
                end
            end
        end
        $display("held-start run of 40 edges complete");
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_held", 32'(ready_w), 32'h7);

        // Reset in the middle of a subtract with A < B
        start = 1'b1; mode = 1'b1; num1 = 8'd30; num2 = 8'd100;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("d%0d_midreset_out", digit_of(i)),
                     32'({res_w[i], carry_w[i], neg_w[i], done_w[i]}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("no_stray_done_c%0d", c), 32'(done_w), 32'd0);
            check_eq($sformatf("ready_idle_c%0d", c), 32'(ready_w), 32'h7);
        end
        $display("mid-operation reset complete");

        // Random scoreboard
        for (int n = 0; n < 1000; n++) begin
            m = 1'($urandom);
            a = pick_operand();
            b = ($urandom_range(0, 15) == 0) ? a : pick_operand();
            run_op(m, a, b, 1'($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
